// File: rtl/led_ind_pkg.sv
// Shared types and constants for the LED value indicator family.
package led_ind_pkg;

  typedef enum logic [1:0] {
    MODE_ONEHOT = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_BAR    = 2'd2,
    MODE_SWEEP  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } sweep_state_t;

  localparam int unsigned PWM_W = 4;

endpackage

// File: rtl/led_tick_gen.sv
// Animation prescaler: counts 0..TICK_DIV-1 and flags the last count as a one-cycle tick.
module led_tick_gen #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;

  // Tick stays asserted during a clr cycle; consumers give clr priority.
  assign tick = (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/led_value_indicator.sv
// Latches an LED index and drives an N_LEDS bank as one-hot, blink, bar or sweep.
// Optional LED_PWM_EN adds a 4-bit duty input that dims every lit LED.
module led_value_indicator
  import led_ind_pkg::*;
#(
  parameter int unsigned N_LEDS   = 16,
  parameter int unsigned SEL_W    = $clog2(N_LEDS),
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SEL_W-1:0]  value,
  input  logic              load,
  input  logic [1:0]        mode,
`ifdef LED_PWM_EN
  input  logic [PWM_W-1:0]  duty,
`endif
  output logic [N_LEDS-1:0] led,
  output logic              busy
);

  function automatic logic [N_LEDS-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N_LEDS-1:0] r;
    for (int unsigned i = 0; i < N_LEDS; i++) r[i] = (SEL_W'(i) == idx);
    return r;
  endfunction

  function automatic logic [N_LEDS-1:0] bar(input logic [SEL_W-1:0] idx);
    logic [N_LEDS-1:0] r;
    for (int unsigned i = 0; i < N_LEDS; i++) r[i] = (SEL_W'(i) <= idx);
    return r;
  endfunction

  mode_t             m;
  mode_t             mode_q;
  sweep_state_t      state, state_nx;
  logic [SEL_W-1:0]  val_q, pos, pos_nx;
  logic              phase;
  logic              tick;
  logic [N_LEDS-1:0] led_nx;

  assign m    = mode_t'(mode);
  assign busy = (state == SCAN);

  led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (load),
    .tick (tick)
  );

  always_comb begin
    state_nx = state;
    pos_nx   = pos;
    if (m != MODE_SWEEP) begin
      state_nx = IDLE;
      pos_nx   = '0;
    end else if (load || (mode_q != MODE_SWEEP)) begin
      state_nx = SCAN;
      pos_nx   = '0;
    end else if ((state == SCAN) && tick) begin
      if (pos == val_q) state_nx = HOLD;
      else              pos_nx   = pos + SEL_W'(1);
    end
  end

  always_comb begin
    led_nx = '0;
    unique case (m)
      MODE_ONEHOT: led_nx = onehot(val_q);
      MODE_BLINK:  led_nx = phase ? onehot(val_q) : '0;
      MODE_BAR:    led_nx = bar(val_q);
      MODE_SWEEP:  led_nx = (state == HOLD) ? onehot(val_q) : onehot(pos);
      default:     led_nx = '0;
    endcase
  end

`ifdef LED_PWM_EN
  logic [PWM_W-1:0] pwm_cnt;

  always_ff @(posedge clk) begin
    if (rst) pwm_cnt <= '0;
    else     pwm_cnt <= pwm_cnt + PWM_W'(1);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q  <= '0;
      phase  <= 1'b1;
      mode_q <= MODE_ONEHOT;
      state  <= IDLE;
      pos    <= '0;
      led    <= '0;
    end else begin
      if (load) begin
        val_q <= (int'(value) > int'(N_LEDS - 1)) ? SEL_W'(N_LEDS - 1) : value;
        phase <= 1'b1;
      end else if (tick) begin
        phase <= ~phase;
      end
      mode_q <= m;
      state  <= state_nx;
      pos    <= pos_nx;
`ifdef LED_PWM_EN
      led    <= led_nx & {N_LEDS{pwm_cnt < duty}};
`else
      led    <= led_nx;
`endif
    end
  end

endmodule

// File: tb/tb_led_value_indicator.sv
// Directed self-checking bench for led_value_indicator (N_LEDS=16 and a clamping N_LEDS=10 instance).
`timescale 1ns/1ps
module tb_led_value_indicator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  value = '0;
  logic        load = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] led;
  logic        busy;

  logic [3:0]  value2 = '0;
  logic        load2 = 1'b0;
  logic [1:0]  mode2 = 2'd0;
  logic [9:0]  led2;
  logic        busy2;

`ifdef LED_PWM_EN
  logic [3:0]  duty = 4'd15;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  led_value_indicator #(.N_LEDS(16), .TICK_DIV(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .value (value),
    .load  (load),
    .mode  (mode),
`ifdef LED_PWM_EN
    .duty  (duty),
`endif
    .led   (led),
    .busy  (busy)
  );

  led_value_indicator #(.N_LEDS(10), .TICK_DIV(4)) dut10 (
    .clk   (clk),
    .rst   (rst),
    .value (value2),
    .load  (load2),
    .mode  (mode2),
`ifdef LED_PWM_EN
    .duty  (duty),
`endif
    .led   (led2),
    .busy  (busy2)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic load_val(input logic [3:0] v);
    value = v;
    load  = 1'b1;
    clk1();
    load  = 1'b0;
  endtask

  initial begin
    clk1();
    clk1();
    check("reset_led", led, 16'h0000);
    check("reset_busy", busy, 1'b0);
    rst = 1'b0;

    // ONEHOT
    load_val(4'd5);
    check("onehot_prev", led, 16'h0001);
    clk1();
    check("onehot_5", led, 16'h0020);
    check("onehot_busy", busy, 1'b0);

    // BLINK: 4 cycles lit, 4 dark, starting lit
    mode = 2'd1;
    load_val(4'd15);
    for (int c = 1; c <= 16; c++) begin
      clk1();
      check($sformatf("blink_c%0d", c), led, (((c - 1) / 4) % 2 == 0) ? 16'h8000 : 16'h0000);
    end

    // BAR
    mode = 2'd2;
    load_val(4'd0);  clk1(); check("bar_0", led, 16'h0001);
    load_val(4'd7);  clk1(); check("bar_7", led, 16'h00FF);
    load_val(4'd15); clk1(); check("bar_15", led, 16'hFFFF);

    // SWEEP to 3
    mode = 2'd3;
    load_val(4'd3);
    check("sweep_busy_start", busy, 1'b1);
    for (int c = 1; c <= 20; c++) begin
      clk1();
      check($sformatf("sweep_led_c%0d", c), led, 16'h0001 << ((c > 16 ? 16 : c) - 1) / 4);
      check($sformatf("sweep_busy_c%0d", c), busy, (c < 16) ? 1'b1 : 1'b0);
    end

    // Restart mid-scan with a load of 1
    load_val(4'd3);
    repeat (5) clk1();
    check("midscan_led", led, 16'h0002);
    load_val(4'd1);
    clk1();
    check("restart_led", led, 16'h0001);
    check("restart_busy", busy, 1'b1);
    repeat (4) clk1();
    check("restart_step", led, 16'h0002);
    check("restart_step_busy", busy, 1'b1);
    repeat (3) clk1();
    check("restart_hold_busy", busy, 1'b0);
    check("restart_hold_led", led, 16'h0002);

    // val_q = 0: one tick of SCAN then HOLD
    load_val(4'd0);
    repeat (3) clk1();
    check("zero_scan_busy", busy, 1'b1);
    clk1();
    check("zero_hold_busy", busy, 1'b0);
    check("zero_hold_led", led, 16'h0001);

    // Leaving mode 3 mid-scan
    load_val(4'd3);
    clk1();
    mode = 2'd0;
    clk1();
    check("leave_busy", busy, 1'b0);
    check("leave_led", led, 16'h0008);

    // Reset during SCAN
    mode = 2'd3;
    load_val(4'd3);
    clk1();
    check("prerst_busy", busy, 1'b1);
    rst = 1'b1;
    clk1();
    check("rst_scan_led", led, 16'h0000);
    check("rst_scan_busy", busy, 1'b0);
    rst = 1'b0;

    // Clamp on the 10-LED instance
    mode2  = 2'd0;
    value2 = 4'd12;
    load2  = 1'b1;
    clk1();
    load2  = 1'b0;
    clk1();
    check("clamp_onehot", led2, 10'h200);
    mode2 = 2'd2;
    clk1();
    check("clamp_bar", led2, 10'h3FF);

`ifdef LED_PWM_EN
    begin
      int hi;
      mode = 2'd0;
      duty = 4'd4;
      load_val(4'd2);
      clk1();
      hi = 0;
      for (int c = 0; c < 16; c++) begin
        clk1();
        if (led[2]) hi++;
      end
      check("pwm_duty4", hi, 4);
      duty = 4'd0;
      clk1();
      hi = 0;
      for (int c = 0; c < 16; c++) begin
        clk1();
        if (led != 16'h0000) hi++;
      end
      check("pwm_duty0", hi, 0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
